wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Consumer end of the writeback interface: integer and FP register files with a
//   per-register pending-write scoreboard. Writes come from the writeback stage
//   (gated write enables, rd, wb_data). Decode reads operands and busy flags
//   combinationally. Issue marks destinations pending; writeback clears them.
// PARAMETERS
//   XLEN   32  register width
//   FP_EN  1   1 = instantiate FP bank and frs1..frs3 ports; 0 = FP reads return 0, never busy
// PORTS
//   clk          in   1     clock, all state updates on rising edge
//   rst          in   1     asynchronous, active-high reset
//   wb_valid_i   in   1     a valid instruction occupies writeback this cycle
//   wb_is_fp_i   in   1     its rd names the FP bank (1) or the integer bank (0)
//   wb_rd_i      in   5     writeback destination
//   wb_data_i    in   XLEN  writeback data
//   wb_wr_en_i   in   1     integer write enable (already exception-gated)
//   wb_fwr_en_i  in   1     FP write enable (already exception-gated)
//   iss_en_i     in   1     decode issues an instruction that will write rd
//   iss_is_fp_i  in   1     issued rd names the FP bank
//   iss_rd_i     in   5     issued destination
//   flush_i      in   1     pipeline flush: drop all pending marks
//   rs1_i/rs2_i  in   5     integer read addresses
//   rs1_o/rs2_o  out  XLEN  integer read data
//   rs1_busy_o/rs2_busy_o  out 1  integer source has a pending writer
//   frs1_i/frs2_i/frs3_i   in  5     FP read addresses (frs3 for fused multiply-add)
//   frs1_o/frs2_o/frs3_o   out XLEN  FP read data
//   frs1_busy_o/frs2_busy_o/frs3_busy_o  out 1  FP source has a pending writer
// BEHAVIOUR
//   Reset: all 32+32 registers = 0, all busy bits = 0. Consequently every *_o = 0
//     and every *_busy_o = 0 while rst is high. Reset mid-operation discards
//     in-flight writes and pending marks immediately (asynchronous).
//   Write: at the clock edge, if wb_wr_en_i, ireg[wb_rd_i] <= wb_data_i, except rd=0.
//     If wb_fwr_en_i, freg[wb_rd_i] <= wb_data_i (f0 is writable). Both enables high
//     in one cycle: both banks are written.
//   Read: combinational, 0-cycle latency. x0 always reads 0. Write-through: if a
//     read address equals wb_rd_i in the same cycle and the matching bank's write
//     enable is high (int: rd!=0), output = wb_data_i, not the stored value.
//   Scoreboard: busy_int[31:1], busy_fp[31:0] registers. busy_int[0] is constant 0.
//     Set: iss_en_i at the edge sets the bit for (iss_is_fp_i, iss_rd_i); int rd=0 is ignored.
//     Clear: wb_valid_i at the edge clears the bit for (wb_is_fp_i, wb_rd_i), independent
//       of wb_wr_en_i/wb_fwr_en_i, so an excepting instruction still releases its rd.
//     Same register set and cleared in one cycle: set wins (new producer owns it).
//     flush_i clears all bits and has priority over set and clear.
//   Busy outputs: *_busy_o = busy[addr] & ~(wb_valid_i & bank match & wb_rd_i==addr).
//     A source retiring this cycle reports not-busy, and its data arrives via
//     write-through, so decode may issue in the same cycle with no bubble.
//   FP_EN=0: FP storage and busy_fp are absent, FP outputs tie to 0, and
//     wb_fwr_en_i/iss_is_fp_i marks are ignored.
//   No internal stall: issue to a register already busy is legal (WAW). The bit
//     stays set until the writer that matches on a wb_valid_i cycle clears it.
// TESTING
//   rst pulse mid-run after writing x5=0x1234 -> rs1_o(x5)=0, all busy=0 during and after reset
//   wb_wr_en_i, rd=0, data=0xDEADBEEF; same cycle rs1_i=0 -> rs1_o=0; next cycle still 0
//   wb_wr_en_i rd=7 data=0xA5A5A5A5, rs2_i=7 same cycle -> rs2_o=0xA5A5A5A5 (bypass); next cycle from storage
//   iss rd=x3 -> rs1_busy_o(x3)=1; later wb_valid_i rd=3 with wb_wr_en_i=0 -> busy_o=0 that cycle, rs1_o=old x3
//   same cycle iss rd=f4 (fp) and wb_valid rd=f4 fp -> frs1_busy_o(f4)=1 next cycle; int x4 unaffected
//   set busy x1,x2,f9 then flush_i together with iss rd=x1 -> all busy 0 next cycle

Source files
------------

// File: rtl/wb_regfile.sv
// Integer and FP register files with write-through reads and a per-register
// pending-write scoreboard, fed by the writeback stage and marked by issue.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter bit FP_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid_i,
  input  logic            wb_is_fp_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            wb_wr_en_i,
  input  logic            wb_fwr_en_i,
  input  logic            iss_en_i,
  input  logic            iss_is_fp_i,
  input  logic [4:0]      iss_rd_i,
  input  logic            flush_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic [XLEN-1:0] rs1_o,
  output logic [XLEN-1:0] rs2_o,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  input  logic [4:0]      frs1_i,
  input  logic [4:0]      frs2_i,
  input  logic [4:0]      frs3_i,
  output logic [XLEN-1:0] frs1_o,
  output logic [XLEN-1:0] frs2_o,
  output logic [XLEN-1:0] frs3_o,
  output logic            frs1_busy_o,
  output logic            frs2_busy_o,
  output logic            frs3_busy_o
);

  function automatic logic [XLEN-1:0] rd_data(input logic [4:0] addr,
                                               input logic [XLEN-1:0] stored,
                                               input logic we,
                                               input logic [4:0] wa,
                                               input logic [XLEN-1:0] wd);
    rd_data = (we && (wa == addr)) ? wd : stored;
  endfunction

  // A source retiring this cycle is reported free; its data arrives by write-through.
  function automatic logic rd_busy(input logic [4:0] addr, input logic busy,
                                   input logic clr, input logic [4:0] wa);
    rd_busy = busy & ~(clr && (wa == addr));
  endfunction

  logic [XLEN-1:0] ireg_q [32];
  logic [XLEN-1:0] ireg_d [32];
  logic [31:0]     busy_int_q, busy_int_d;
  logic            int_we, int_clr;

  assign int_we  = wb_wr_en_i && (wb_rd_i != 5'd0);
  assign int_clr = wb_valid_i && !wb_is_fp_i;

  always_comb begin
    ireg_d = ireg_q;
    if (int_we) ireg_d[wb_rd_i] = wb_data_i;
    busy_int_d = busy_int_q;
    if (int_clr) busy_int_d[wb_rd_i] = 1'b0;
    // Set after clear so a new producer keeps ownership.
    if (iss_en_i && !iss_is_fp_i) busy_int_d[iss_rd_i] = 1'b1;
    busy_int_d[0] = 1'b0;
    if (flush_i) busy_int_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ireg_q     <= '{default: '0};
      busy_int_q <= '0;
    end else begin
      ireg_q     <= ireg_d;
      busy_int_q <= busy_int_d;
    end
  end

  assign rs1_o = (rst || rs1_i == 5'd0) ? '0
               : rd_data(rs1_i, ireg_q[rs1_i], int_we, wb_rd_i, wb_data_i);
  assign rs2_o = (rst || rs2_i == 5'd0) ? '0
               : rd_data(rs2_i, ireg_q[rs2_i], int_we, wb_rd_i, wb_data_i);
  assign rs1_busy_o = !rst && rd_busy(rs1_i, busy_int_q[rs1_i], int_clr, wb_rd_i);
  assign rs2_busy_o = !rst && rd_busy(rs2_i, busy_int_q[rs2_i], int_clr, wb_rd_i);

  if (FP_EN) begin : g_fp
    logic [XLEN-1:0] freg_q [32];
    logic [XLEN-1:0] freg_d [32];
    logic [31:0]     busy_fp_q, busy_fp_d;
    logic            fp_clr;

    assign fp_clr = wb_valid_i && wb_is_fp_i;

    always_comb begin
      freg_d = freg_q;
      if (wb_fwr_en_i) freg_d[wb_rd_i] = wb_data_i;
      busy_fp_d = busy_fp_q;
      if (fp_clr) busy_fp_d[wb_rd_i] = 1'b0;
      if (iss_en_i && iss_is_fp_i) busy_fp_d[iss_rd_i] = 1'b1;
      if (flush_i) busy_fp_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        freg_q    <= '{default: '0};
        busy_fp_q <= '0;
      end else begin
        freg_q    <= freg_d;
        busy_fp_q <= busy_fp_d;
      end
    end

    assign frs1_o = rst ? '0 : rd_data(frs1_i, freg_q[frs1_i], wb_fwr_en_i, wb_rd_i, wb_data_i);
    assign frs2_o = rst ? '0 : rd_data(frs2_i, freg_q[frs2_i], wb_fwr_en_i, wb_rd_i, wb_data_i);
    assign frs3_o = rst ? '0 : rd_data(frs3_i, freg_q[frs3_i], wb_fwr_en_i, wb_rd_i, wb_data_i);
    assign frs1_busy_o = !rst && rd_busy(frs1_i, busy_fp_q[frs1_i], fp_clr, wb_rd_i);
    assign frs2_busy_o = !rst && rd_busy(frs2_i, busy_fp_q[frs2_i], fp_clr, wb_rd_i);
    assign frs3_busy_o = !rst && rd_busy(frs3_i, busy_fp_q[frs3_i], fp_clr, wb_rd_i);
  end else begin : g_no_fp
    assign frs1_o      = '0;
    assign frs2_o      = '0;
    assign frs3_o      = '0;
    assign frs1_busy_o = 1'b0;
    assign frs2_busy_o = 1'b0;
    assign frs3_busy_o = 1'b0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector bench for wb_regfile: a table of per-cycle inputs with
// hand-computed combinational outputs, plus a mid-run asynchronous reset sequence.
module tb_wb_regfile;

  logic        clk, rst;
  logic        wb_valid_i, wb_is_fp_i, wb_wr_en_i, wb_fwr_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        iss_en_i, iss_is_fp_i, flush_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  rs1_i, rs2_i, frs1_i, frs2_i, frs3_i;
  logic [31:0] rs1_o, rs2_o, frs1_o, frs2_o, frs3_o;
  logic        rs1_busy_o, rs2_busy_o, frs1_busy_o, frs2_busy_o, frs3_busy_o;

  int n_vec  = 0;
  int n_fail = 0;

  wb_regfile #(.XLEN(32), .FP_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid_i), .wb_is_fp_i(wb_is_fp_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i), .wb_wr_en_i(wb_wr_en_i), .wb_fwr_en_i(wb_fwr_en_i),
    .iss_en_i(iss_en_i), .iss_is_fp_i(iss_is_fp_i), .iss_rd_i(iss_rd_i),
    .flush_i(flush_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .frs1_i(frs1_i), .frs2_i(frs2_i), .frs3_i(frs3_i),
    .frs1_o(frs1_o), .frs2_o(frs2_o), .frs3_o(frs3_o),
    .frs1_busy_o(frs1_busy_o), .frs2_busy_o(frs2_busy_o), .frs3_busy_o(frs3_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wbv, wbfp, wbrd, wdat, wen, fwen, iss, issfp, issrd, fl;
    logic [31:0] rs1, rs2, f1, f2, f3;
    logic [31:0] e_rs1, e_rs2, e_rb1, e_rb2, e_f1, e_f2, e_f3, e_fb1, e_fb2, e_fb3;
  } vec_t;

  localparam int NV = 32;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wb_valid_i = 0; wb_is_fp_i = 0; wb_rd_i = 0; wb_data_i = 0;
    wb_wr_en_i = 0; wb_fwr_en_i = 0;
    iss_en_i = 0; iss_is_fp_i = 0; iss_rd_i = 0; flush_i = 0;
    rs1_i = 0; rs2_i = 0; frs1_i = 0; frs2_i = 0; frs3_i = 0;
  endtask

  task automatic drive(input vec_t v);
    wb_valid_i = v.wbv[0]; wb_is_fp_i = v.wbfp[0]; wb_rd_i = v.wbrd[4:0];
    wb_data_i = v.wdat; wb_wr_en_i = v.wen[0]; wb_fwr_en_i = v.fwen[0];
    iss_en_i = v.iss[0]; iss_is_fp_i = v.issfp[0]; iss_rd_i = v.issrd[4:0];
    flush_i = v.fl[0];
    rs1_i = v.rs1[4:0]; rs2_i = v.rs2[4:0];
    frs1_i = v.f1[4:0]; frs2_i = v.f2[4:0]; frs3_i = v.f3[4:0];
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d rs1_o", i), rs1_o, v.e_rs1);
    chk($sformatf("v%0d rs2_o", i), rs2_o, v.e_rs2);
    chk($sformatf("v%0d rs1_busy", i), {31'b0, rs1_busy_o}, v.e_rb1);
    chk($sformatf("v%0d rs2_busy", i), {31'b0, rs2_busy_o}, v.e_rb2);
    chk($sformatf("v%0d frs1_o", i), frs1_o, v.e_f1);
    chk($sformatf("v%0d frs2_o", i), frs2_o, v.e_f2);
    chk($sformatf("v%0d frs3_o", i), frs3_o, v.e_f3);
    chk($sformatf("v%0d frs1_busy", i), {31'b0, frs1_busy_o}, v.e_fb1);
    chk($sformatf("v%0d frs2_busy", i), {31'b0, frs2_busy_o}, v.e_fb2);
    chk($sformatf("v%0d frs3_busy", i), {31'b0, frs3_busy_o}, v.e_fb3);
  endtask

  localparam logic [31:0] A5 = 32'hA5A5A5A5;
  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] D9 = 32'h11112222;

  initial begin
    //          wbv fp rd wdat         wen fwen iss ifp ird fl  rs1 rs2 f1 f2 f3   ers1 ers2 rb1 rb2 ef1 ef2 ef3 fb1 fb2 fb3
    vt[0]  = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  0, 5, 0, 1, 31,  0,  0,  0, 0, 0,  0,  0,  0, 0, 0};
    vt[1]  = '{1, 0, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0,  0,  0, 0, 0,  0,  0,  0, 0, 0};
    vt[2]  = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0,  0,  0, 0, 0,  0,  0,  0, 0, 0};
    vt[3]  = '{1, 0, 7, A5,           1, 0, 0, 0, 0, 0,  7, 7, 7, 0, 0,   A5, A5, 0, 0, 0,  0,  0,  0, 0, 0};
    vt[4]  = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  0, 7, 7, 0, 0,   0,  A5, 0, 0, 0,  0,  0,  0, 0, 0};
    vt[5]  = '{1, 1, 0, F1,           0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0,  0,  0, 0, F1, F1, F1, 0, 0, 0};
    vt[6]  = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0,   0,  0,  0, 0, F1, 0,  F1, 0, 0, 0};
    vt[7]  = '{1, 0, 9, D9,           1, 1, 0, 0, 0, 0,  9, 0, 0, 1, 9,   D9, 0,  0, 0, F1, 0,  D9, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  9, 9, 9, 0, 9,   D9, D9, 0, 0, D9, F1, D9, 0, 0, 0};
    vt[9]  = '{1, 0, 3, 32'h33,       1, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0,   32'h33, 0, 0, 0, F1, F1, F1, 0, 0, 0};
    vt[10] = '{0, 0, 0, 0,            0, 0, 1, 0, 3, 0,  3, 3, 3, 0, 0,   32'h33, 32'h33, 0, 0, 0, F1, F1, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  3, 3, 3, 0, 0,   32'h33, 32'h33, 1, 1, 0, F1, F1, 0, 0, 0};
    vt[12] = '{1, 0, 3, 32'hBAD,      0, 0, 0, 0, 0, 0,  3, 3, 3, 0, 0,   32'h33, 32'h33, 0, 0, 0, F1, F1, 0, 0, 0};
    vt[13] = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  3, 3, 3, 0, 0,   32'h33, 32'h33, 0, 0, 0, F1, F1, 0, 0, 0};
    vt[14] = '{0, 0, 0, 0,            0, 0, 1, 1, 4, 0,  4, 0, 4, 0, 0,   0,  0,  0, 0, 0,  F1, F1, 0, 0, 0};
    vt[15] = '{1, 1, 4, 0,            0, 0, 1, 1, 4, 0,  4, 0, 4, 0, 0,   0,  0,  0, 0, 0,  F1, F1, 0, 0, 0};
    vt[16] = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  4, 0, 4, 4, 0,   0,  0,  0, 0, 0,  0,  F1, 1, 1, 0};
    vt[17] = '{0, 0, 0, 0,            0, 0, 1, 0, 0, 0,  0, 0, 4, 0, 0,   0,  0,  0, 0, 0,  F1, F1, 1, 0, 0};
    vt[18] = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  0, 0, 4, 0, 0,   0,  0,  0, 0, 0,  F1, F1, 1, 0, 0};
    vt[19] = '{0, 0, 0, 0,            0, 0, 1, 0, 1, 0,  1, 0, 0, 0, 0,   0,  0,  0, 0, F1, F1, F1, 0, 0, 0};
    vt[20] = '{0, 0, 0, 0,            0, 0, 1, 0, 2, 0,  1, 2, 0, 0, 0,   0,  0,  1, 0, F1, F1, F1, 0, 0, 0};
    vt[21] = '{0, 0, 0, 0,            0, 0, 1, 1, 9, 0,  1, 2, 9, 0, 0,   0,  0,  1, 1, D9, F1, F1, 0, 0, 0};
    vt[22] = '{0, 0, 0, 0,            0, 0, 1, 0, 1, 1,  1, 2, 9, 4, 0,   0,  0,  1, 1, D9, 0,  F1, 1, 1, 0};
    vt[23] = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  1, 2, 9, 4, 0,   0,  0,  0, 0, D9, 0,  F1, 0, 0, 0};
    vt[24] = '{0, 0, 0, 0,            0, 0, 1, 0, 6, 0,  6, 0, 0, 0, 0,   0,  0,  0, 0, F1, F1, F1, 0, 0, 0};
    vt[25] = '{0, 0, 0, 0,            0, 0, 1, 0, 6, 0,  6, 0, 0, 0, 0,   0,  0,  1, 0, F1, F1, F1, 0, 0, 0};
    vt[26] = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  6, 0, 0, 0, 0,   0,  0,  1, 0, F1, F1, F1, 0, 0, 0};
    vt[27] = '{1, 0, 6, 32'h66,       1, 0, 0, 0, 0, 0,  6, 0, 0, 0, 0,   32'h66, 0, 0, 0, F1, F1, F1, 0, 0, 0};
    vt[28] = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  6, 0, 0, 0, 0,   32'h66, 0, 0, 0, F1, F1, F1, 0, 0, 0};
    vt[29] = '{0, 0, 0, 0,            0, 0, 1, 1, 6, 0,  6, 0, 6, 0, 0,   32'h66, 0, 0, 0, 0, F1, F1, 0, 0, 0};
    vt[30] = '{1, 0, 6, 0,            0, 0, 0, 0, 0, 0,  6, 0, 6, 0, 0,   32'h66, 0, 0, 0, 0, F1, F1, 1, 0, 0};
    vt[31] = '{0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  6, 0, 6, 0, 0,   32'h66, 0, 0, 0, 0, F1, F1, 1, 0, 0};

    // Reset state: a write-through attempt must not leak while rst is high.
    rst = 1'b1;
    idle();
    wb_valid_i = 1; wb_wr_en_i = 1; wb_fwr_en_i = 1; wb_rd_i = 7; wb_data_i = 32'hFFFF;
    rs1_i = 7; frs1_i = 7;
    #2;
    chk("reset rs1_o", rs1_o, 32'h0);
    chk("reset frs1_o", frs1_o, 32'h0);
    chk("reset rs1_busy", {31'b0, rs1_busy_o}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vt[i]);
      #3;
      check_vec(i, vt[i]);
    end

    // Mid-run asynchronous reset discards stored data, pending marks and in-flight writes.
    @(posedge clk);
    #1;
    idle();
    wb_valid_i = 1; wb_wr_en_i = 1; wb_rd_i = 5; wb_data_i = 32'h1234;
    @(posedge clk);
    #1;
    idle();
    rs1_i = 5; rs2_i = 7; frs1_i = 6;
    #1;
    chk("pre-rst x5", rs1_o, 32'h1234);
    chk("pre-rst f6 busy", {31'b0, frs1_busy_o}, 32'h1);
    wb_valid_i = 1; wb_wr_en_i = 1; wb_rd_i = 5; wb_data_i = 32'h9999;
    #1;
    rst = 1'b1;
    #1;
    chk("in-rst x5", rs1_o, 32'h0);
    chk("in-rst x7", rs2_o, 32'h0);
    chk("in-rst f6 busy", {31'b0, frs1_busy_o}, 32'h0);
    @(posedge clk);
    #1;
    chk("in-rst edge x5", rs1_o, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    rs1_i = 5; rs2_i = 7; frs1_i = 6; frs2_i = 0;
    #1;
    chk("post-rst x5", rs1_o, 32'h0);
    chk("post-rst x7", rs2_o, 32'h0);
    chk("post-rst f6 busy", {31'b0, frs1_busy_o}, 32'h0);
    chk("post-rst f0", frs2_o, 32'h0);
    @(posedge clk);
    #1;
    chk("post-rst edge x5", rs1_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
